// File: rtl/seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_scheduler
// Brief    : Arbitrates one 4-digit multiplexed 7-seg display between two
//            round-robin requesters and a preemptive, blinking alert source.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_scheduler #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLINK_HALF   = 500,
    parameter int ALERT_MIN    = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [15:0] a_bcd,
    input  logic        b_req,
    input  logic [15:0] b_bcd,
    input  logic        alert_req,
    input  logic [15:0] alert_bcd,
    output logic [15:0] bcd_out,
    output logic        blank,
    output logic [1:0]  src_sel,
    output logic        bcd_err
);

    localparam int DW = $clog2(DWELL_CYCLES) + 1;
    localparam int BW = $clog2(BLINK_HALF) + 1;
    localparam int AW = $clog2(ALERT_MIN) + 1;

    localparam logic [DW-1:0] c_dwell_last = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] c_blink_last = BW'(BLINK_HALF - 1);
    localparam logic [AW-1:0] c_alert_last = AW'(ALERT_MIN - 1);

    // Encoding doubles as the src_sel value.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHOW_A = 2'b01,
        ST_SHOW_B = 2'b10,
        ST_ALERT  = 2'b11
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_dwell;
    logic [BW-1:0]   r_blink;
    logic [AW-1:0]   r_alert_cnt;
    logic            r_phase_on;
    logic            r_last_b;
    logic            r_ret_b;

    state_t          w_next;
    logic            w_phase_next;
    logic            w_update;
    logic [15:0]     w_src;
    logic [15:0]     w_clean;
    logic [3:0]      w_bad;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (alert_req)
                    w_next = ST_ALERT;
                else if (a_req && b_req)
                    w_next = r_last_b ? ST_SHOW_A : ST_SHOW_B;
                else if (a_req)
                    w_next = ST_SHOW_A;
                else if (b_req)
                    w_next = ST_SHOW_B;
            end
            ST_SHOW_A: begin
                if (alert_req)
                    w_next = ST_ALERT;
                else if (!a_req)
                    w_next = b_req ? ST_SHOW_B : ST_IDLE;
                else if (b_req && (r_dwell == c_dwell_last))
                    w_next = ST_SHOW_B;
            end
            ST_SHOW_B: begin
                if (alert_req)
                    w_next = ST_ALERT;
                else if (!b_req)
                    w_next = a_req ? ST_SHOW_A : ST_IDLE;
                else if (a_req && (r_dwell == c_dwell_last))
                    w_next = ST_SHOW_A;
            end
            ST_ALERT: begin
                // Prefer the preempted source, then the other one.
                if (!alert_req && (r_alert_cnt == c_alert_last)) begin
                    if (r_ret_b ? b_req : a_req)
                        w_next = r_ret_b ? ST_SHOW_B : ST_SHOW_A;
                    else if (r_ret_b ? a_req : b_req)
                        w_next = r_ret_b ? ST_SHOW_A : ST_SHOW_B;
                    else
                        w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_phase_next = 1'b1;
        if (r_state == ST_ALERT)
            w_phase_next = (r_blink == c_blink_last) ? ~r_phase_on : r_phase_on;
    end

    always_comb begin
        w_src = bcd_out;
        case (w_next)
            ST_SHOW_A: w_src = a_bcd;
            ST_SHOW_B: w_src = b_bcd;
            ST_ALERT:  w_src = alert_bcd;
            default:   w_src = bcd_out;
        endcase
    end

    // Display is lit (and bcd_out refreshed) whenever a source is actually shown.
    assign w_update = (w_next == ST_SHOW_A) || (w_next == ST_SHOW_B) ||
                      ((w_next == ST_ALERT) && w_phase_next);

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_digit
            assign w_bad[g]           = (w_src[4*g +: 4] > 4'd9);
            assign w_clean[4*g +: 4]  = w_bad[g] ? 4'h0 : w_src[4*g +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dwell     <= '0;
            r_blink     <= '0;
            r_alert_cnt <= '0;
            r_phase_on  <= 1'b1;
            r_last_b    <= 1'b1;
            r_ret_b     <= 1'b0;
            bcd_out     <= 16'h0000;
            blank       <= 1'b1;
            src_sel     <= 2'b00;
            bcd_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            src_sel <= w_next;
            blank   <= ~w_update;
            bcd_err <= 1'b0;
            if (w_update) begin
                bcd_out <= w_clean;
                bcd_err <= |w_bad;
            end

            if (w_next != r_state)
                r_dwell <= '0;
            else if (r_dwell != c_dwell_last)
                r_dwell <= r_dwell + 1'b1;

            if (w_next == ST_SHOW_A)
                r_last_b <= 1'b0;
            else if (w_next == ST_SHOW_B)
                r_last_b <= 1'b1;

            if ((w_next == ST_ALERT) && (r_state == ST_SHOW_A))
                r_ret_b <= 1'b0;
            else if ((w_next == ST_ALERT) && (r_state == ST_SHOW_B))
                r_ret_b <= 1'b1;

            if (w_next == ST_ALERT) begin
                r_phase_on <= w_phase_next;
                if (r_state != ST_ALERT) begin
                    r_alert_cnt <= '0;
                    r_blink     <= '0;
                end else begin
                    if (r_alert_cnt != c_alert_last)
                        r_alert_cnt <= r_alert_cnt + 1'b1;
                    r_blink <= (r_blink == c_blink_last) ? '0 : r_blink + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_scheduler
// Brief    : Directed-vector bench for seg_display_scheduler (small params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_scheduler;

    logic        clk;
    logic        rst_n;
    logic        a_req;
    logic [15:0] a_bcd;
    logic        b_req;
    logic [15:0] b_bcd;
    logic        alert_req;
    logic [15:0] alert_bcd;
    logic [15:0] bcd_out;
    logic        blank;
    logic [1:0]  src_sel;
    logic        bcd_err;

    int n_vec;
    int n_err;

    seg_display_scheduler #(
        .DWELL_CYCLES (8),
        .BLINK_HALF   (4),
        .ALERT_MIN    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_bcd     (a_bcd),
        .b_req     (b_req),
        .b_bcd     (b_bcd),
        .alert_req (alert_req),
        .alert_bcd (alert_bcd),
        .bcd_out   (bcd_out),
        .blank     (blank),
        .src_sel   (src_sel),
        .bcd_err   (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        a_req     = 1'b0;
        a_bcd     = 16'h0;
        b_req     = 1'b0;
        b_bcd     = 16'h0;
        alert_req = 1'b0;
        alert_bcd = 16'h0;

        // Reset held with random activity on the inputs
        for (int i = 0; i < 4; i++) begin
            a_req     = 1'($urandom);
            b_req     = 1'($urandom);
            alert_req = 1'($urandom);
            a_bcd     = 16'($urandom);
            b_bcd     = 16'($urandom);
            alert_bcd = 16'($urandom);
            tick();
            check_val("rst_bcd", 32'(bcd_out), 32'h0000);
            check_val("rst_blank", 32'(blank), 32'd1);
            check_val("rst_sel", 32'(src_sel), 32'd0);
        end
        a_req = 1'b0; b_req = 1'b0; alert_req = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        check_val("idle_bcd", 32'(bcd_out), 32'h0000);
        check_val("idle_blank", 32'(blank), 32'd1);
        check_val("idle_sel", 32'(src_sel), 32'd0);
        check_val("idle_err", 32'(bcd_err), 32'd0);

        // Sole requester A, held long: no rotation
        a_req = 1'b1;
        a_bcd = 16'h2345;
        tick();
        check_val("a_sel", 32'(src_sel), 32'd1);
        check_val("a_blank", 32'(blank), 32'd0);
        check_val("a_bcd", 32'(bcd_out), 32'h2345);
        for (int i = 0; i < 50; i++) begin
            tick();
            check_val("a_hold_sel", 32'(src_sel), 32'd1);
        end

        // Fresh reset, then A+B tie: A first, 8-cycle rotation
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_req = 1'b1; b_req = 1'b1;
        a_bcd = 16'h2345; b_bcd = 16'h4856;
        for (int k = 0; k < 32; k++) begin
            tick();
            check_val("rr_bcd", 32'(bcd_out), ((k / 8) % 2 == 0) ? 32'h2345 : 32'h4856);
            check_val("rr_sel", 32'(src_sel), ((k / 8) % 2 == 0) ? 32'd1 : 32'd2);
        end

        // B alone (dwell saturated), then alert preempts
        a_req = 1'b0;
        tick();
        check_val("b_only_sel", 32'(src_sel), 32'd2);
        alert_req = 1'b1;
        alert_bcd = 16'h2019;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (j == 2) alert_req = 1'b0;
            check_val("al_sel", 32'(src_sel), 32'd3);
            check_val("al_blank", 32'(blank), ((j / 4) % 2 == 1) ? 32'd1 : 32'd0);
            check_val("al_bcd", 32'(bcd_out), 32'h2019);
        end
        tick();
        check_val("ret_sel", 32'(src_sel), 32'd2);
        check_val("ret_blank", 32'(blank), 32'd0);
        check_val("ret_bcd", 32'(bcd_out), 32'h4856);
        // Dwell restarted: B keeps the display for 8 cycles total after return
        a_req = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            check_val("ret_dwell_b", 32'(src_sel), 32'd2);
        end
        tick();
        check_val("ret_dwell_a", 32'(src_sel), 32'd1);

        // Digit sanitising
        b_req = 1'b0;
        a_bcd = 16'h1A3F;
        tick();
        check_val("san_bcd", 32'(bcd_out), 32'h1030);
        check_val("san_err", 32'(bcd_err), 32'd1);
        a_bcd = 16'h9A09;
        tick();
        check_val("san_bcd2", 32'(bcd_out), 32'h9009);
        check_val("san_err2", 32'(bcd_err), 32'd1);
        a_bcd = 16'h2345;
        tick();
        check_val("san_clean", 32'(bcd_out), 32'h2345);
        check_val("san_noerr", 32'(bcd_err), 32'd0);

        // Reset asserted mid-alert
        alert_req = 1'b1;
        tick();
        tick();
        tick();
        check_val("pre_rst_sel", 32'(src_sel), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_blank", 32'(blank), 32'd1);
        check_val("async_sel", 32'(src_sel), 32'd0);
        check_val("async_bcd", 32'(bcd_out), 32'h0000);
        alert_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_val("post_rst_sel", 32'(src_sel), 32'd1);
        check_val("post_rst_bcd", 32'(bcd_out), 32'h2345);
        check_val("post_rst_blank", 32'(blank), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
